// File: rtl/fft_pkg.sv
// Shared constants and types for the radix-2 DIT FFT: sequencer states,
// address/twiddle index widths and the Q8.8 complex formats.
package fft_pkg;

  localparam int LOG2N_DEF  = 4;
  localparam int N_DEF      = 1 << LOG2N_DEF;
  localparam int BF_LAT_DEF = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef logic [LOG2N_DEF-1:0]         addr_t;
  typedef logic [LOG2N_DEF-2:0]         twk_t;
  typedef logic [$clog2(LOG2N_DEF)-1:0] stage_t;

  typedef logic signed [15:0] q8_8_t;

  typedef struct packed {
    q8_8_t re;
    q8_8_t im;
  } cplx_t;

  typedef cplx_t sample_t;
  typedef cplx_t twiddle_t;

endpackage

// File: rtl/fft_seq_ctrl_if.sv
// Control/address bundle between the FFT top FSM (master) and the
// butterfly sequencer (slave).
interface fft_seq_ctrl_if #(
  parameter int LOG2N = fft_pkg::LOG2N_DEF
);
  localparam int SW = $clog2(LOG2N);

  logic             start;
  logic             busy;
  logic             done;
  logic [SW-1:0]    stage;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] tw_k;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;

  modport master (
    output start,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_k,
    input  wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    input  start,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_k,
    output wr_en, wr_addr_a, wr_addr_b
  );

endinterface

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address/twiddle generator: (stage s, butterfly j)
// -> operand pair spaced 2^s apart and the twiddle LUT index.
module fft_addr_gen #(
  parameter int LOG2N = fft_pkg::LOG2N_DEF
) (
  input  logic [$clog2(LOG2N)-1:0] s,
  input  logic [LOG2N-2:0]         j,
  output logic [LOG2N-1:0]         addr_a,
  output logic [LOG2N-1:0]         addr_b,
  output logic [LOG2N-2:0]         tw_k
);

  logic [LOG2N-1:0] jw;
  logic [LOG2N-1:0] half;
  logic [LOG2N-1:0] pos;

  assign jw   = {1'b0, j};
  assign half = LOG2N'(1) << s;
  assign pos  = jw & (half - 1'b1);

  // Insert a zero at bit s of j; shifting twice avoids overflowing s+1.
  assign addr_a = (((jw >> s) << s) << 1) | pos;
  assign addr_b = addr_a + half;

  // pos < 2^s, so it always fits in the narrower twiddle index.
  assign tw_k = pos[LOG2N-2:0] << (LOG2N - 1 - int'(s));

endmodule

// File: rtl/fft_seq_ctrl.sv
// In-place radix-2 DIT FFT sequencer: streams butterfly reads stage by stage,
// replays each address pair as a write BF_LAT cycles later, drains between stages.
module fft_seq_ctrl
  import fft_pkg::*;
#(
  parameter int LOG2N  = LOG2N_DEF,
  parameter int BF_LAT = BF_LAT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  fft_seq_ctrl_if.slave  bus
);

  localparam int N2 = 1 << (LOG2N - 1);
  localparam int SW = $clog2(LOG2N);
  localparam int JW = LOG2N - 1;
  localparam int CW = $clog2(BF_LAT) + 1;

  typedef struct packed {
    logic             v;
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
  } wr_ent_t;

  state_e           state;
  logic [JW-1:0]    j_q;
  logic [SW-1:0]    stage_q;
  logic [CW-1:0]    drain_q;
  logic             busy_q, done_q, rd_en_q;
  logic [LOG2N-1:0] rd_a_q, rd_b_q;
  logic [JW-1:0]    tw_q;
  wr_ent_t          dl [BF_LAT];

  logic [SW-1:0]    gen_s;
  logic [JW-1:0]    gen_j;
  logic [LOG2N-1:0] gen_a, gen_b;
  logic [JW-1:0]    gen_k;

  // The generator looks one butterfly ahead so the read registers load
  // the address of the butterfly they are about to present.
  // NOTE: defaults first in always_comb so no path leaves a latch.
  always_comb begin
    gen_s = stage_q;
    gen_j = j_q + 1'b1;
    if (state == S_IDLE) begin
      gen_s = '0;
      gen_j = '0;
    end else if (state == S_DRAIN) begin
      gen_s = stage_q + 1'b1;
      gen_j = '0;
    end
  end

  fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .s      (gen_s),
    .j      (gen_j),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .tw_k   (gen_k)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      j_q     <= '0;
      stage_q <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          state   <= S_READ;
          j_q     <= '0;
          stage_q <= '0;
          busy_q  <= 1'b1;
          rd_en_q <= 1'b1;
          rd_a_q  <= gen_a;
          rd_b_q  <= gen_b;
          tw_q    <= gen_k;
        end
        S_READ: if (j_q == JW'(N2 - 1)) begin
          state   <= S_DRAIN;
          drain_q <= '0;
          rd_en_q <= 1'b0;
        end else begin
          j_q    <= j_q + 1'b1;
          rd_a_q <= gen_a;
          rd_b_q <= gen_b;
          tw_q   <= gen_k;
        end
        // Holding reads until the last write of this stage lands avoids
        // the in-place read-after-write hazard across stages.
        S_DRAIN: if (drain_q == CW'(BF_LAT - 1)) begin
          if (stage_q == SW'(LOG2N - 1)) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state   <= S_READ;
            stage_q <= stage_q + 1'b1;
            j_q     <= '0;
            rd_en_q <= 1'b1;
            rd_a_q  <= gen_a;
            rd_b_q  <= gen_b;
            tw_q    <= gen_k;
          end
        end else begin
          drain_q <= drain_q + 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the delay line is reset on purpose so an aborted transform
  // never emits a stale write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BF_LAT; i++) dl[i] <= '0;
    end else begin
      dl[0] <= '{v: rd_en_q, a: rd_a_q, b: rd_b_q};
      for (int i = 1; i < BF_LAT; i++) dl[i] <= dl[i-1];
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stage     = stage_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_a = rd_a_q;
  assign bus.rd_addr_b = rd_b_q;
  assign bus.tw_k      = tw_q;
  assign bus.wr_en     = dl[BF_LAT-1].v;
  assign bus.wr_addr_a = dl[BF_LAT-1].a;
  assign bus.wr_addr_b = dl[BF_LAT-1].b;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Bench for fft_seq_ctrl: cycle-level arithmetic model of the transform
// schedule, a read->write scoreboard and hand-computed anchor values.
module tb_fft_seq_ctrl;
  import fft_pkg::*;

  localparam int LOG2N = LOG2N_DEF;
  localparam int N2    = N_DEF / 2;
  localparam int BFL   = BF_LAT_DEF;
  localparam int L     = N2 + BFL;
  localparam int LAST  = LOG2N * L;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_seq_ctrl_if #(.LOG2N(LOG2N)) bus ();

  fft_seq_ctrl #(.LOG2N(LOG2N), .BF_LAT(BFL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;
  bit run      = 1'b0;
  bit chk_en   = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Operation r (0-based, counted from the first read cycle) of a run:
  // stage = r / L, slot within the stage = r % L; slots >= N/2 are the drain.
  function automatic void op(input int r, output bit v, output int s,
                             output int a, output int b, output int k);
    int j, half, lo;
    v = 1'b0; s = 0; a = 0; b = 0; k = 0;
    if (r < 0) return;
    s = r / L;
    j = r % L;
    if (s >= LOG2N || j >= N2) return;
    v    = 1'b1;
    half = 1 << s;
    lo   = j % half;
    a    = (j / half) * 2 * half + lo;
    b    = a + half;
    k    = lo * (N2 / half);
  endfunction

  // Model of start acceptance: a run owns the block until the cycle after done.
  always @(posedge clk) begin
    if (rst) run = 1'b0;
    else if (bus.start && (!run || cyc >= t0 + LAST + 2)) begin
      run = 1'b1;
      t0  = cyc;
    end
    cyc++;
  end

  typedef struct { int c; int a; int b; } rd_rec_t;
  rd_rec_t q[$];
  int rd_cnt = 0;
  int wr_cnt = 0;

  always @(negedge clk) if (chk_en) begin
    int d;
    bit rv, wv;
    int rs, ra, rb, rk, ws, wa, wb, wk;
    rd_rec_t e;
    d = run ? cyc - t0 : -1;
    op(run ? d - 1 : -1, rv, rs, ra, rb, rk);
    op(run ? d - 1 - BFL : -1, wv, ws, wa, wb, wk);
    check("busy", bus.busy, run && d >= 1 && d <= LAST);
    check("done", bus.done, run && d == LAST + 1);
    check("rd_en", bus.rd_en, rv);
    if (rv) begin
      check("rd_addr_a", bus.rd_addr_a, ra);
      check("rd_addr_b", bus.rd_addr_b, rb);
      check("tw_k", bus.tw_k, rk);
      check("stage", bus.stage, rs);
    end
    check("wr_en", bus.wr_en, wv);
    if (wv) begin
      check("wr_addr_a", bus.wr_addr_a, wa);
      check("wr_addr_b", bus.wr_addr_b, wb);
    end
    if (d == 1) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end
    if (!run) q.delete();
    if (bus.wr_en === 1'b1) begin
      wr_cnt++;
      check("sb_pending_read", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("sb_wr_delay", cyc - e.c, BFL);
        check("sb_wr_a", bus.wr_addr_a, e.a);
        check("sb_wr_b", bus.wr_addr_b, e.b);
      end
    end
    if (bus.rd_en === 1'b1) begin
      rd_cnt++;
      e = '{cyc, int'(bus.rd_addr_a), int'(bus.rd_addr_b)};
      q.push_back(e);
    end
    if (run && d == LAST + 1) begin
      check("rd_count", rd_cnt, 32);
      check("wr_count", wr_cnt, 32);
    end
  end

  task automatic goto(int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    goto(2);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset held for two cycles while idle.
    goto(5);  rst = 1'b1;
    goto(7);  rst = 1'b0;
    check("lit_rst_busy", bus.busy, 0);
    check("lit_rst_done", bus.done, 0);
    check("lit_rst_rd_en", bus.rd_en, 0);
    check("lit_rst_wr_en", bus.wr_en, 0);
    check("lit_rst_rd_a", bus.rd_addr_a, 0);
    check("lit_rst_tw", bus.tw_k, 0);
    check("lit_rst_wr_b", bus.wr_addr_b, 0);
    check("lit_rst_stage", bus.stage, 0);

    // Run A: start sampled at cycle 8.
    goto(8);  bus.start = 1'b1;
    goto(9);  bus.start = 1'b0;
    check("lit_first_rd_en", bus.rd_en, 1);
    check("lit_first_rd_a", bus.rd_addr_a, 0);
    check("lit_first_rd_b", bus.rd_addr_b, 1);
    check("lit_first_tw", bus.tw_k, 0);
    check("lit_first_busy", bus.busy, 1);
    goto(12);
    check("lit_first_wr_en", bus.wr_en, 1);
    check("lit_first_wr_a", bus.wr_addr_a, 0);
    check("lit_first_wr_b", bus.wr_addr_b, 1);
    goto(16);
    check("lit_s0_last_a", bus.rd_addr_a, 14);
    check("lit_s0_last_b", bus.rd_addr_b, 15);
    goto(17);
    check("lit_drain_rd_en", bus.rd_en, 0);
    goto(18); bus.start = 1'b1;
    goto(19); bus.start = 1'b0;
    check("lit_drain_end_rd_en", bus.rd_en, 0);
    goto(20);
    check("lit_s1_first_stage", bus.stage, 1);
    check("lit_s1_first_b", bus.rd_addr_b, 2);
    goto(25);
    check("lit_s1j5_a", bus.rd_addr_a, 9);
    check("lit_s1j5_b", bus.rd_addr_b, 11);
    check("lit_s1j5_tw", bus.tw_k, 4);
    goto(36);
    check("lit_s2j5_a", bus.rd_addr_a, 9);
    check("lit_s2j5_b", bus.rd_addr_b, 13);
    check("lit_s2j5_tw", bus.tw_k, 2);
    goto(47);
    check("lit_s3j5_a", bus.rd_addr_a, 5);
    check("lit_s3j5_b", bus.rd_addr_b, 13);
    check("lit_s3j5_tw", bus.tw_k, 5);
    check("lit_s3j5_stage", bus.stage, 3);
    goto(52);
    check("lit_last_wr_en", bus.wr_en, 1);
    check("lit_last_wr_a", bus.wr_addr_a, 7);
    check("lit_last_wr_b", bus.wr_addr_b, 15);
    check("lit_last_busy", bus.busy, 1);
    goto(53);
    check("lit_done", bus.done, 1);
    check("lit_done_busy", bus.busy, 0);
    check("lit_done_wr_en", bus.wr_en, 0);
    bus.start = 1'b1;
    goto(54);
    check("lit_after_done", bus.done, 0);
    check("lit_idle_busy", bus.busy, 0);
    goto(55); bus.start = 1'b0;
    check("lit_restart_rd_en", bus.rd_en, 1);
    check("lit_restart_busy", bus.busy, 1);

    // Run B (t0 = 54) aborted by reset at its cycle 20.
    goto(74); rst = 1'b1;
    goto(75); rst = 1'b0;
    check("lit_abort_rd_en", bus.rd_en, 0);
    check("lit_abort_wr_en", bus.wr_en, 0);
    check("lit_abort_busy", bus.busy, 0);
    check("lit_abort_done", bus.done, 0);
    check("lit_abort_rd_a", bus.rd_addr_a, 0);
    check("lit_abort_stage", bus.stage, 0);

    // Run C: complete transform after the abort.
    goto(80); bus.start = 1'b1;
    goto(81); bus.start = 1'b0;
    check("lit_c_rd_en", bus.rd_en, 1);
    goto(124);
    check("lit_c_last_wr_en", bus.wr_en, 1);
    goto(125);
    check("lit_c_done", bus.done, 1);
    goto(126);
    check("lit_c_done_pulse", bus.done, 0);

    goto(130);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
